// File: rtl/enocoro_pkg.sv
// Shared Enocoro GF(2^8) definitions for the nibble-serial datapaths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   GF_POLY_LO  low byte of the field polynomial x^8+x^4+x^3+x^2+1 (0x11D)
//   phase_e     nibble phase of a byte on a 4-bit stream (low nibble first)
package enocoro_pkg;

  localparam logic [7:0] GF_POLY_LO = 8'h1D;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/gf_byte_fifo.sv
// Byte FIFO, DEPTH entries of 8 bits, with synchronous flush.
// Latency: a push is visible on pop_dat / empty the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   clear              synchronous flush; wins over push and pop
//   push, push_dat     write request and data
//   pop                read request; pop_dat is the head entry (valid when !empty)
//   full, empty        derived from the registered occupancy count
module gf_byte_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] pop_dat,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    pop_dat = mem_q[rd_ptr_q];

    do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push = push & (~full | do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/div_by_0x02_4bits.sv
// Nibble-serial GF(2^8) divide-by-0x02 (multiply by 0x8E) over poly 0x11D, low nibble first in and out.
// Latency: low nibble in at t, high at t+1, quotient low nibble out at t+2, high nibble at t+3.
// Backpressure: in_ready drops on the high nibble while the byte FIFO is full and no byte is leaving.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   clear                    synchronous flush of partial byte and queued quotients
//   in_valid/in_ready/in_nib input nibble stream (b[3:0] then b[7:4])
//   out_valid/out_ready      output nibble handshake
//   out_nib, out_hi          quotient nibble (r[3:0] then r[7:4]) and its phase flag
module div_by_0x02_4bits
  import enocoro_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_nib,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_nib,
  output logic       out_hi
);

  // Division by x: an odd byte first has the reduction polynomial folded out,
  // then the shifted-out x^0 term re-enters as x^7 (x^-1 = x^7 + x^3 + x^2 + x).
  function automatic logic [7:0] gf_div2(input logic [7:0] b);
    logic [7:0] r;
    if (b[0]) begin
      r = ((b ^ GF_POLY_LO) >> 1) | 8'h80;
    end else begin
      r = b >> 1;
    end
    return r;
  endfunction

  phase_e     in_ph_q, in_ph_d;
  phase_e     out_ph_q, out_ph_d;
  logic [3:0] lo_hold_q, lo_hold_d;

  logic       fifo_push, fifo_pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic [7:0] push_byte;
  logic       pop_byte;
  logic       in_fire, out_fire;

  always_comb begin
    out_valid = ~fifo_empty;
    out_hi    = ~fifo_empty & (out_ph_q == PH_HI);
    out_nib   = '0;
    if (!fifo_empty) begin
      out_nib = (out_ph_q == PH_HI) ? fifo_head[7:4] : fifo_head[3:0];
    end

    // A byte leaving on this edge frees a slot for the byte completing now.
    pop_byte = out_valid & out_ready & (out_ph_q == PH_HI);
    in_ready = (in_ph_q == PH_LO) | ~fifo_full | pop_byte;

    // Handshakes during clear are ignored entirely.
    in_fire  = in_valid & in_ready & ~clear;
    out_fire = out_valid & out_ready & ~clear;

    push_byte = gf_div2({in_nib, lo_hold_q});
    fifo_push = in_fire & (in_ph_q == PH_HI);
    fifo_pop  = out_fire & (out_ph_q == PH_HI);

    in_ph_d   = in_ph_q;
    out_ph_d  = out_ph_q;
    lo_hold_d = lo_hold_q;

    if (clear) begin
      in_ph_d   = PH_LO;
      out_ph_d  = PH_LO;
      lo_hold_d = '0;
    end else begin
      if (in_fire) begin
        in_ph_d = (in_ph_q == PH_LO) ? PH_HI : PH_LO;
        if (in_ph_q == PH_LO) begin
          lo_hold_d = in_nib;
        end
      end
      if (out_fire) begin
        out_ph_d = (out_ph_q == PH_LO) ? PH_HI : PH_LO;
      end
    end
  end

  // Input assembly and output serialization phase FSMs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ph_q   <= PH_LO;
      out_ph_q  <= PH_LO;
      lo_hold_q <= '0;
    end else begin
      in_ph_q   <= in_ph_d;
      out_ph_q  <= out_ph_d;
      lo_hold_q <= lo_hold_d;
    end
  end

  gf_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .push     (fifo_push),
    .push_dat (push_byte),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_div_by_0x02_4bits.sv
// Directed bench for the nibble-serial divide-by-0x02 block (DEPTH = 2).
module tb_div_by_0x02_4bits;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_nib;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_nib;
  logic       out_hi;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] stim_q[$];
  logic [3:0] got_q[$];
  logic [3:0] exp1 [8] = '{4'hE, 4'h8, 4'h1, 4'h0, 4'h0, 4'h8, 4'h1, 4'hF};
  logic [3:0] bp_nibs [5] = '{4'h3, 4'h0, 4'h0, 4'h8, 4'h5};
  logic [7:0] rnd_b [1000];

  always #5 clk = ~clk;

  div_by_0x02_4bits #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nib    (in_nib),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nib   (out_nib),
    .out_hi    (out_hi)
  );

  // Independent reference: forward multiply by 0x02 modulo 0x11D.
  function automatic logic [7:0] mul2(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams stim_q with in_valid/out_ready held high; captures outputs in got_q.
  task automatic stream_nibbles();
    int n;
    n = stim_q.size();
    got_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < n + 2; k++) begin
      in_valid = (k < n);
      in_nib   = (k < n) ? stim_q[k] : 4'h0;
      #1;
      if (k < n) check("stream_in_ready", in_ready, 1);
      if (k >= 2) begin
        check("stream_out_valid", out_valid, 1);
        check("stream_out_hi", out_hi, (k - 2) % 2);
        got_q.push_back(out_nib);
      end else begin
        check("stream_startup_idle", out_valid, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("stream_drained", out_valid, 0);
  endtask

  initial begin
    int sent, rcv, cyc;
    logic stalled, st_hi;
    logic [3:0] st_nib, lo_got;

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_nib = 4'h0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_nib", out_nib, 0);
    check("rst_out_hi", out_hi, 0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Known vectors 0x01, 0x02, 0x1D, 0xFF.
    stim_q = '{4'h1, 4'h0, 4'h2, 4'h0, 4'hD, 4'h1, 4'hF, 4'hF};
    stream_nibbles();
    for (int i = 0; i < 8; i++) check($sformatf("vec_nib%0d", i), got_q[i], exp1[i]);

    // All 256 bytes back to back; quotient must map back under multiply-by-2.
    stim_q.delete();
    for (int b = 0; b < 256; b++) begin
      stim_q.push_back(4'(b));
      stim_q.push_back(4'(b >> 4));
    end
    stream_nibbles();
    for (int b = 0; b < 256; b++)
      check($sformatf("exh_%02h", b), mul2({got_q[2*b+1], got_q[2*b]}), b);

    // Backpressure: 0x03, 0x80 queued, 0x55 blocked on its high nibble.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_nib = bp_nibs[i];
      #1;
      check("bp_accept", in_ready, 1);
      tick();
    end
    in_nib = 4'h5;
    #1;
    check("bp_full_rdy", in_ready, 0);
    check("bp_head_vld", out_valid, 1);
    check("bp_head_nib", out_nib, 4'hF);
    check("bp_head_hi", out_hi, 0);
    tick();
    check("bp_still_full", in_ready, 0);
    check("bp_stable_nib", out_nib, 4'hF);
    out_ready = 1'b1;
    #1;
    check("bp_lo_no_room", in_ready, 0);
    tick();
    check("bp_pushpop_rdy", in_ready, 1);
    check("bp_hi_nib", out_nib, 4'h8);
    check("bp_hi_flag", out_hi, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_b1_lo", out_nib, 4'h0);
    tick();
    check("bp_b1_hi", out_nib, 4'h4);
    tick();
    check("bp_b2_lo", out_nib, 4'h4);
    check("bp_b2_lo_flag", out_hi, 0);
    tick();
    check("bp_b2_hi", out_nib, 4'hA);
    tick();
    check("bp_empty", out_valid, 0);

    // Clear with two queued bytes and a held low nibble.
    out_ready = 1'b0;
    stim_q = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_nib = stim_q[i];
      tick();
    end
    clear = 1'b1; in_nib = 4'h4; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_nib", out_nib, 0);
    check("clr_in_ready", in_ready, 1);
    stim_q = '{4'hD, 4'h1};
    stream_nibbles();
    check("clr_new_lo", got_q[0], 4'h0);
    check("clr_new_hi", got_q[1], 4'h8);

    // Random stalls over 1000 bytes.
    for (int i = 0; i < 1000; i++) rnd_b[i] = 8'($urandom);
    sent = 0; rcv = 0; cyc = 0; stalled = 1'b0; st_nib = '0; st_hi = 1'b0; lo_got = '0;
    while (rcv < 2000 && cyc < 20000) begin
      in_valid  = (sent < 2000) && ($urandom_range(0, 3) != 0);
      in_nib    = (sent < 2000) ? ((sent % 2 == 1) ? rnd_b[sent / 2][7:4] : rnd_b[sent / 2][3:0]) : 4'h0;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        check("rnd_stall_vld", out_valid, 1);
        check("rnd_stall_nib", out_nib, st_nib);
        check("rnd_stall_hi", out_hi, st_hi);
      end
      if (out_valid && out_ready) begin
        check("rnd_phase", out_hi, rcv % 2);
        if (rcv % 2 == 0) lo_got = out_nib;
        else check("rnd_quot", mul2({out_nib, lo_got}), rnd_b[rcv / 2]);
        rcv++;
      end
      stalled = out_valid && !out_ready;
      st_nib  = out_nib;
      st_hi   = out_hi;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_all_received", rcv, 2000);

    // Asynchronous reset while the high nibble is on the output.
    out_ready = 1'b0;
    stim_q = '{4'h7, 4'h0};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_nib = stim_q[i];
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("ares_pre_hi", out_hi, 1);
    reset_n = 1'b0;
    #1;
    check("ares_out_valid", out_valid, 0);
    check("ares_out_nib", out_nib, 0);
    check("ares_out_hi", out_hi, 0);
    tick();
    reset_n = 1'b1;
    #1;
    stim_q = '{4'h2, 4'h0};
    stream_nibbles();
    check("ares_new_lo", got_q[0], 4'h1);
    check("ares_new_hi", got_q[1], 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
